mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-master request ports and shared memory bus for mem_arbiter
interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic              req0;
    logic              req1;
    logic [1:0]        cmd0;
    logic [1:0]        cmd1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    // Requesters plus the RAM / I/O decode side of the shared bus.
    modport master (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, read_data,
        input  done0, done1, rdata, busy, mem_cmd, mem_addr, write_data
    );

    // The arbiter itself.
    modport slave (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, read_data,
        output done0, done1, rdata, busy, mem_cmd, mem_addr, write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory bus arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic              grant_id;
    logic              elig0;
    logic              elig1;
    logic              pick1;
    logic [1:0]        sel_cmd;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant;
`endif

    always_comb begin
        elig0 = bus.req0 && ((bus.cmd0 == MREAD) || (bus.cmd0 == MWRITE));
        elig1 = bus.req1 && ((bus.cmd1 == MREAD) || (bus.cmd1 == MWRITE));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie the port that was not granted last time wins.
        pick1 = elig1 && (!elig0 || (last_grant == 1'b0));
`else
        pick1 = elig1 && !elig0;
`endif
        sel_cmd   = pick1 ? bus.cmd1   : bus.cmd0;
        sel_addr  = pick1 ? bus.addr1  : bus.addr0;
        sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
    end

    // The bus output registers double as the latch of the winning request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            grant_id       <= 1'b0;
            bus.done0      <= 1'b0;
            bus.done1      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.mem_cmd    <= MNONE;
            bus.mem_addr   <= '0;
            bus.write_data <= '0;
            bus.rdata      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        grant_id       <= pick1;
                        bus.mem_cmd    <= sel_cmd;
                        bus.mem_addr   <= sel_addr;
                        bus.write_data <= sel_wdata;
                        bus.busy       <= 1'b1;
                        state          <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant     <= pick1;
`endif
                    end
                end
                ACCESS: begin
                    if (bus.mem_cmd == MWRITE) begin
                        bus.mem_cmd    <= MNONE;
                        bus.mem_addr   <= '0;
                        bus.write_data <= '0;
                        bus.done0      <= ~grant_id;
                        bus.done1      <= grant_id;
                        state          <= DONE;
                    end else begin
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    // RAM data appears one cycle after the address, i.e. now.
                    bus.rdata      <= bus.read_data;
                    bus.mem_cmd    <= MNONE;
                    bus.mem_addr   <= '0;
                    bus.write_data <= '0;
                    bus.done0      <= ~grant_id;
                    bus.done1      <= grant_id;
                    state          <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (honours MEM_ARB_ROUND_ROBIN_EN)
module tb_mem_arbiter;
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [15:0] ram [0:319];
    logic [7:0]  sw;
    int   done_cyc [0:7];
    int   done_id  [0:7];
    int   n_done;
    logic both_done;

    mem_arbiter_if #(.DATA_W(16), .ADDR_W(9)) bus ();

    mem_arbiter #(.DATA_W(16), .ADDR_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM at 0x000-0x13F, switches at 0x140, anything else reads 16'hDEAD.
    always @(posedge clk) begin
        if (reset) ram[5] <= 16'h1234;
        if (bus.mem_cmd == MWRITE && bus.mem_addr < 9'd320) ram[bus.mem_addr] <= bus.write_data;
        if (bus.mem_addr < 9'd320)       bus.read_data <= ram[bus.mem_addr];
        else if (bus.mem_addr == 9'h140) bus.read_data <= {8'h00, sw};
        else                             bus.read_data <= 16'hDEAD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req_set(input int port, input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wd);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.cmd0 = cmd; bus.addr0 = addr; bus.wdata0 = wd;
        end else begin
            bus.req1 = 1'b1; bus.cmd1 = cmd; bus.addr1 = addr; bus.wdata1 = wd;
        end
    endtask

    task automatic req_clr();
        bus.req0 = 1'b0; bus.cmd0 = MNONE; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.cmd1 = MNONE; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        sw    = 8'h5A;
        reset = 1'b1;
        req_clr();
        tick();
        tick();
        chk("rst_busy",  bus.busy, 0);
        chk("rst_cmd",   bus.mem_cmd, MNONE);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.write_data, 0);
        chk("rst_done",  {bus.done0, bus.done1}, 0);
        chk("rst_rdata", bus.rdata, 0);
        reset = 1'b0;
        tick();

        // Port 0 write 00AB -> 0x100
        req_set(0, MWRITE, 9'h100, 16'h00AB);
        tick();
        chk("w0_acc_cmd",   bus.mem_cmd, MWRITE);
        chk("w0_acc_addr",  bus.mem_addr, 9'h100);
        chk("w0_acc_wdata", bus.write_data, 16'h00AB);
        chk("w0_acc_busy",  bus.busy, 1);
        chk("w0_acc_done",  bus.done0, 0);
        tick();
        chk("w0_done0", bus.done0, 1);
        chk("w0_done1", bus.done1, 0);
        chk("w0_bus",   bus.mem_cmd, MNONE);
        chk("w0_rdata", bus.rdata, 0);
        req_clr();
        tick();
        chk("w0_idle_done", bus.done0, 0);
        chk("w0_idle_busy", bus.busy, 0);
        chk("w0_ram",       ram[9'h100], 16'h00AB);

        // Port 1 read of RAM 0x005
        req_set(1, MREAD, 9'h005, 16'h0000);
        tick();
        chk("r1_acc_cmd",  bus.mem_cmd, MREAD);
        chk("r1_acc_addr", bus.mem_addr, 9'h005);
        tick();
        chk("r1_wait_cmd",  bus.mem_cmd, MREAD);
        chk("r1_wait_done", bus.done1, 0);
        tick();
        chk("r1_done1", bus.done1, 1);
        chk("r1_done0", bus.done0, 0);
        chk("r1_rdata", bus.rdata, 16'h1234);
        chk("r1_bus",   bus.mem_cmd, MNONE);
        req_clr();
        tick();
        chk("r1_hold", bus.rdata, 16'h1234);

        // Port 0 read of switches
        req_set(0, MREAD, 9'h140, 16'h0000);
        tick(); tick(); tick();
        chk("sw_done0", bus.done0, 1);
        chk("sw_rdata", bus.rdata, 16'h005A);
        req_clr();
        tick();

        // A write leaves rdata untouched
        req_set(1, MWRITE, 9'h010, 16'h7777);
        tick(); tick();
        chk("w1_done1", bus.done1, 1);
        chk("w1_rdata", bus.rdata, 16'h005A);
        req_clr();
        tick();
        chk("w1_ram", ram[9'h010], 16'h7777);

        // Out-of-map read runs the normal sequence
        req_set(0, MREAD, 9'h180, 16'h0000);
        tick();
        chk("oom_acc_addr", bus.mem_addr, 9'h180);
        tick(); tick();
        chk("oom_done0", bus.done0, 1);
        chk("oom_rdata", bus.rdata, 16'hDEAD);
        req_clr();
        tick();

        // Request arriving while busy waits and is not lost
        req_set(0, MREAD, 9'h005, 16'h0000);
        tick();
        req_set(1, MWRITE, 9'h030, 16'h3333);
        tick(); tick();
        chk("pend_done0", bus.done0, 1);
        req_clr();
        req_set(1, MWRITE, 9'h030, 16'h3333);
        tick(); tick();
        chk("pend_acc_cmd",  bus.mem_cmd, MWRITE);
        chk("pend_acc_addr", bus.mem_addr, 9'h030);
        tick();
        chk("pend_done1", bus.done1, 1);
        req_clr();
        tick();

        // Invalid commands are ignored
        req_set(1, 2'b10, 9'h005, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bad_cmd_idle", {bus.busy, bus.mem_cmd, bus.done1}, 0);
        end
        req_clr();
        req_set(1, MNONE, 9'h005, 16'h0000);
        tick(); tick();
        chk("none_cmd_idle", {bus.busy, bus.mem_cmd, bus.done1}, 0);
        req_clr();

        // Both ports hold writes continuously, fresh from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_set(0, MWRITE, 9'h020, 16'h1111);
        req_set(1, MWRITE, 9'h021, 16'h2222);
        n_done = 0;
        both_done = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.done0 && bus.done1) both_done = 1'b1;
            if ((bus.done0 || bus.done1) && n_done < 8) begin
                done_cyc[n_done] = i;
                done_id[n_done]  = bus.done1 ? 1 : 0;
                n_done++;
            end
        end
        req_clr();
        tick();
        chk("b2b_count", n_done, 4);
        chk("b2b_both",  both_done, 0);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_cycle", done_cyc[k], 2 + 3 * k);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("b2b_grant", done_id[k], k % 2);
`else
            chk("b2b_grant", done_id[k], 0);
`endif
        end
        chk("b2b_ram0", ram[9'h020], 16'h1111);

        // Reset during RWAIT of a port 1 read aborts it
        req_set(1, MREAD, 9'h005, 16'h0000);
        tick(); tick();
        chk("abort_wait_cmd", bus.mem_cmd, MREAD);
        reset = 1'b1;
        tick();
        chk("abort_busy",  bus.busy, 0);
        chk("abort_cmd",   bus.mem_cmd, MNONE);
        chk("abort_done1", bus.done1, 0);
        chk("abort_rdata", bus.rdata, 0);
        reset = 1'b0;
        req_clr();
        tick();
        chk("abort_after_done1", bus.done1, 0);
        tick();
        chk("abort_after_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
